rob_value_buffer: RTL and testbench

- Multi-port, multi-bus result buffer indexed by ROB tag, used at rename to fetch source operands that are already computed.
- Each entry holds a ready bit and a data word.
  - Written by any of NCDB common-data-bus broadcasts.
  - Cleared by any of NCOMMIT commit ports, or all at once by flush.
- NRD registered read ports, with same-cycle CDB bypass. Replaces the fixed 2-read/1-CDB/8-entry buffer.

---
 rtl/rob_pkg.sv | 16 +
 rtl/rob_value_read_port.sv | 61 ++++++
 rtl/rob_value_buffer.sv | 124 ++++++++++++
 tb/tb_rob_value_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared ROB definitions: default sizing, tag type and CDB broadcast record.
package rob_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROBW      = $clog2(ROB_DEPTH);
    localparam int WIDTH     = 32;

    typedef logic [ROBW-1:0] rob_tag_t;

    typedef struct packed {
        logic             valid;
        rob_tag_t         rob;
        logic [WIDTH-1:0] result;
    } cdb_t;

endpackage

// File: rtl/rob_value_read_port.sv
// One rename read port: captures the entry's next state, then bypasses a
// matching CDB broadcast on the following cycle.
module rob_value_read_port
    import rob_pkg::*;
#(
    parameter int ROBW  = 3,
    parameter int WIDTH = 32,
    parameter int NCDB  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ROBW-1:0]       rob,
    input  logic                  ready_next,
    input  logic [WIDTH-1:0]      data_next,
    input  logic                  flush,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*ROBW-1:0]  cdb_rob,
    input  logic [NCDB*WIDTH-1:0] cdb_result,
    output logic                  valid,
    output logic [WIDTH-1:0]      value
);

    logic             valid_q;
    logic [WIDTH-1:0] value_q;
    logic [ROBW-1:0]  rob_q;
    logic             hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            value_q <= '0;
            rob_q   <= '0;
        end else if (en) begin
            valid_q <= ready_next & ~flush;
            value_q <= data_next;
            rob_q   <= rob;
        end else begin
            valid_q <= 1'b0;
        end
    end

    // Lowest-numbered bus wins the bypass; flush suppresses it entirely.
    always_comb begin
        valid = valid_q;
        value = value_q;
        hit   = 1'b0;
        for (int unsigned b = 0; b < NCDB; b++) begin
            if (!hit && cdb_valid[b] && cdb_rob[b*ROBW +: ROBW] == rob_q) begin
                hit   = 1'b1;
                valid = 1'b1;
                value = cdb_result[b*WIDTH +: WIDTH];
            end
        end
        if (flush) begin
            valid = 1'b0;
            value = value_q;
        end
    end

endmodule

// File: rtl/rob_value_buffer.sv
// ROB-tag-indexed result buffer with NCDB writers, NCOMMIT clears and NRD reads.
// Optional ready_count output under ROB_VALUE_BUFFER_OCCUPANCY_EN.
module rob_value_buffer #(
    parameter int   ROB_DEPTH = rob_pkg::ROB_DEPTH,
    parameter int   WIDTH     = rob_pkg::WIDTH,
    parameter int   NRD       = 2,
    parameter int   NCDB      = 1,
    parameter int   NCOMMIT   = 1,
    localparam int  ROBW      = $clog2(ROB_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCDB-1:0]          cdb_valid,
    input  logic [NCDB*ROBW-1:0]     cdb_rob,
    input  logic [NCDB*WIDTH-1:0]    cdb_result,
    input  logic [NRD-1:0]           rd_en,
    input  logic [NRD*ROBW-1:0]      rd_rob,
    input  logic [NCOMMIT-1:0]       commit_valid,
    input  logic [NCOMMIT*ROBW-1:0]  commit_rob,
    input  logic                     flush,
    output logic [NRD-1:0]           rd_valid,
    output logic [NRD*WIDTH-1:0]     rd_value
`ifdef ROB_VALUE_BUFFER_OCCUPANCY_EN
    ,
    output logic [ROBW:0]            ready_count
`endif
);

    import rob_pkg::*;

    logic [ROB_DEPTH-1:0] ready;
    logic [ROB_DEPTH-1:0] ready_nx;
    logic [WIDTH-1:0]     data    [ROB_DEPTH];
    logic [WIDTH-1:0]     data_nx [ROB_DEPTH];

    // Buses applied highest index first so the lowest bus is the final writer.
    always_comb begin
        ready_nx = ready;
        data_nx  = data;
        for (int unsigned i = 0; i < NCDB; i++) begin
            automatic int unsigned b = NCDB - 1 - i;
            if (cdb_valid[b]) begin
                ready_nx[cdb_rob[b*ROBW +: ROBW]] = 1'b1;
                data_nx[cdb_rob[b*ROBW +: ROBW]]  = cdb_result[b*WIDTH +: WIDTH];
            end
        end
        for (int unsigned c = 0; c < NCOMMIT; c++) begin
            if (commit_valid[c]) begin
                ready_nx[commit_rob[c*ROBW +: ROBW]] = 1'b0;
            end
        end
        if (flush) begin
            ready_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= '0;
        end else begin
            ready <= ready_nx;
        end
    end

    always_ff @(posedge clk) begin
        data <= data_nx;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ROBW-1:0] tag;
        assign tag = rd_rob[p*ROBW +: ROBW];

        rob_value_read_port #(
            .ROBW  (ROBW),
            .WIDTH (WIDTH),
            .NCDB  (NCDB)
        ) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (rd_en[p]),
            .rob        (tag),
            .ready_next (ready_nx[tag]),
            .data_next  (data_nx[tag]),
            .flush      (flush),
            .cdb_valid  (cdb_valid),
            .cdb_rob    (cdb_rob),
            .cdb_result (cdb_result),
            .valid      (rd_valid[p]),
            .value      (rd_value[p*WIDTH +: WIDTH])
        );
    end

    for (genvar b1 = 0; b1 < NCDB; b1++) begin : g_cdb_chk
        for (genvar b2 = b1 + 1; b2 < NCDB; b2++) begin : g_pair
            assert property (@(posedge clk) disable iff (!rst_n)
                !(cdb_valid[b1] && cdb_valid[b2] &&
                  cdb_rob[b1*ROBW +: ROBW] == cdb_rob[b2*ROBW +: ROBW]));
        end
    end

`ifdef ROB_VALUE_BUFFER_OCCUPANCY_EN
    localparam int CW = ROBW + 1;
    logic [CW-1:0] count_nx;

    always_comb begin
        count_nx = '0;
        for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            count_nx = count_nx + CW'(ready_nx[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_count <= '0;
        end else begin
            ready_count <= count_nx;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        ready_count == CW'($countones(ready)));
`endif

endmodule

// File: tb/tb_rob_value_buffer.sv
// Directed self-checking bench for rob_value_buffer (default and 4-read/2-CDB builds).
module tb_rob_value_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    // default instance: NRD=2, NCDB=1
    logic [0:0]  cdb_valid = '0;
    logic [2:0]  cdb_rob = '0;
    logic [31:0] cdb_result = '0;
    logic [1:0]  rd_en = '0;
    logic [5:0]  rd_rob = '0;
    logic [0:0]  commit_valid = '0;
    logic [2:0]  commit_rob = '0;
    logic        flush = 1'b0;
    logic [1:0]  rd_valid;
    logic [63:0] rd_value;
`ifdef ROB_VALUE_BUFFER_OCCUPANCY_EN
    logic [3:0]  ready_count;
`endif

    // wide instance: NRD=4, NCDB=2
    logic [1:0]   m_cdb_valid = '0;
    logic [5:0]   m_cdb_rob = '0;
    logic [63:0]  m_cdb_result = '0;
    logic [3:0]   m_rd_en = '0;
    logic [11:0]  m_rd_rob = '0;
    logic [0:0]   m_commit_valid = '0;
    logic [2:0]   m_commit_rob = '0;
    logic         m_flush = 1'b0;
    logic [3:0]   m_rd_valid;
    logic [127:0] m_rd_value;
`ifdef ROB_VALUE_BUFFER_OCCUPANCY_EN
    logic [3:0]   m_ready_count;
`endif

    always #5 clk = ~clk;

    rob_value_buffer u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cdb_valid    (cdb_valid),
        .cdb_rob      (cdb_rob),
        .cdb_result   (cdb_result),
        .rd_en        (rd_en),
        .rd_rob       (rd_rob),
        .commit_valid (commit_valid),
        .commit_rob   (commit_rob),
        .flush        (flush),
        .rd_valid     (rd_valid),
        .rd_value     (rd_value)
`ifdef ROB_VALUE_BUFFER_OCCUPANCY_EN
        ,
        .ready_count  (ready_count)
`endif
    );

    rob_value_buffer #(.NRD(4), .NCDB(2)) u_wide (
        .clk          (clk),
        .rst_n        (rst_n),
        .cdb_valid    (m_cdb_valid),
        .cdb_rob      (m_cdb_rob),
        .cdb_result   (m_cdb_result),
        .rd_en        (m_rd_en),
        .rd_rob       (m_rd_rob),
        .commit_valid (m_commit_valid),
        .commit_rob   (m_commit_rob),
        .flush        (m_flush),
        .rd_valid     (m_rd_valid),
        .rd_value     (m_rd_value)
`ifdef ROB_VALUE_BUFFER_OCCUPANCY_EN
        ,
        .ready_count  (m_ready_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if (rd_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_rd_valid got=%b exp=%b", rd_valid, 2'b00);
        end
        vectors++;
        if (rd_value !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_rd_value got=%h exp=%h", rd_value, 64'h0);
        end
        vectors++;
        if (m_rd_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_wide_rd_valid got=%b exp=%b", m_rd_valid, 4'b0000);
        end
`ifdef ROB_VALUE_BUFFER_OCCUPANCY_EN
        vectors++;
        if (ready_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_ready_count got=%0d exp=0", ready_count);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cdb_then_read();
        cdb_valid = 1'b1; cdb_rob = 3'd3; cdb_result = 32'hDEAD_BEEF;
        tick();
        cdb_valid = 1'b0;
        rd_en = 2'b01; rd_rob = {3'd0, 3'd3};
        tick();
        rd_en = 2'b00;
        vectors++;
        if (rd_valid[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL cdb_read_valid got=%b exp=1", rd_valid[0]);
        end
        vectors++;
        if (rd_value[31:0] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL cdb_read_value got=%h exp=%h", rd_value[31:0], 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_bypass();
        // write and read in the same cycle
        rd_en = 2'b10; rd_rob = {3'd5, 3'd0};
        cdb_valid = 1'b1; cdb_rob = 3'd5; cdb_result = 32'h0000_1234;
        tick();
        rd_en = 2'b00; cdb_valid = 1'b0;
        vectors++;
        if (rd_valid[1] !== 1'b1 || rd_value[63:32] !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL same_cycle_write got=%b/%h exp=1/%h", rd_valid[1], rd_value[63:32], 32'h1234);
        end
        // clear tag 5, read it not-ready, then bypass in the following cycle
        commit_valid = 1'b1; commit_rob = 3'd5;
        tick();
        commit_valid = 1'b0;
        rd_en = 2'b10; rd_rob = {3'd5, 3'd0};
        tick();
        rd_en = 2'b00;
        vectors++;
        if (rd_valid[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL read_after_commit got=%b exp=0", rd_valid[1]);
        end
        cdb_valid = 1'b1; cdb_rob = 3'd5; cdb_result = 32'hCAFE_0005;
        #1;
        vectors++;
        if (rd_valid[1] !== 1'b1 || rd_value[63:32] !== 32'hCAFE_0005) begin
            miscompares++;
            $display("FAIL next_cycle_bypass got=%b/%h exp=1/%h", rd_valid[1], rd_value[63:32], 32'hCAFE_0005);
        end
        flush = 1'b1;
        #1;
        vectors++;
        if (rd_valid[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_under_flush got=%b exp=0", rd_valid[1]);
        end
        flush = 1'b0; cdb_valid = 1'b0;
        tick();
    endtask

    task automatic test_commit();
        cdb_valid = 1'b1; cdb_rob = 3'd2; cdb_result = 32'hAAAA_0002;
        tick();
        cdb_valid = 1'b0;
        commit_valid = 1'b1; commit_rob = 3'd2;
        rd_en = 2'b01; rd_rob = {3'd0, 3'd2};
        tick();
        commit_valid = 1'b0; rd_en = 2'b00;
        vectors++;
        if (rd_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL commit_same_edge_read got=%b exp=0", rd_valid[0]);
        end
        commit_valid = 1'b1; commit_rob = 3'd2;
        cdb_valid = 1'b1; cdb_rob = 3'd2; cdb_result = 32'hBBBB_0002;
        tick();
        commit_valid = 1'b0; cdb_valid = 1'b0;
        rd_en = 2'b01; rd_rob = {3'd0, 3'd2};
        tick();
        rd_en = 2'b00;
        vectors++;
        if (rd_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL commit_and_cdb_ready got=%b exp=0", rd_valid[0]);
        end
        vectors++;
        if (rd_value[31:0] !== 32'hBBBB_0002) begin
            miscompares++;
            $display("FAIL commit_and_cdb_data got=%h exp=%h", rd_value[31:0], 32'hBBBB_0002);
        end
    endtask

    task automatic test_multi_port();
        m_cdb_valid = 2'b11;
        m_cdb_rob = {3'd7, 3'd0};
        m_cdb_result = {32'h7000_0007, 32'h1000_0000};
        tick();
        m_cdb_valid = 2'b00;
        m_rd_en = 4'hF;
        m_rd_rob = {3'd1, 3'd0, 3'd7, 3'd0};
        tick();
        m_rd_en = 4'h0;
        vectors++;
        if (m_rd_valid !== 4'b0111) begin
            miscompares++;
            $display("FAIL multi_valid got=%b exp=%b", m_rd_valid, 4'b0111);
        end
        vectors++;
        if (m_rd_value[95:0] !== {32'h1000_0000, 32'h7000_0007, 32'h1000_0000}) begin
            miscompares++;
            $display("FAIL multi_value got=%h exp=%h", m_rd_value[95:0],
                     {32'h1000_0000, 32'h7000_0007, 32'h1000_0000});
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) begin
            cdb_valid = 1'b1; cdb_rob = 3'(i); cdb_result = 32'h100 + 32'(i);
            tick();
        end
        cdb_valid = 1'b0;
`ifdef ROB_VALUE_BUFFER_OCCUPANCY_EN
        vectors++;
        if (ready_count !== 4'd8) begin
            miscompares++;
            $display("FAIL count_full got=%0d exp=8", ready_count);
        end
`endif
        rd_en = 2'b01; rd_rob = {3'd0, 3'd6};
        tick();
        rd_en = 2'b00;
        vectors++;
        if (rd_valid[0] !== 1'b1 || rd_value[31:0] !== 32'h106) begin
            miscompares++;
            $display("FAIL prefill_read got=%b/%h exp=1/%h", rd_valid[0], rd_value[31:0], 32'h106);
        end
        flush = 1'b1;
        rd_en = 2'b11; rd_rob = {3'd4, 3'd1};
        tick();
        flush = 1'b0; rd_en = 2'b00;
        vectors++;
        if (rd_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL read_at_flush got=%b exp=00", rd_valid);
        end
`ifdef ROB_VALUE_BUFFER_OCCUPANCY_EN
        vectors++;
        if (ready_count !== 4'd0) begin
            miscompares++;
            $display("FAIL count_flushed got=%0d exp=0", ready_count);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            rd_en = 2'b11; rd_rob = {3'(2*i+1), 3'(2*i)};
            tick();
            vectors++;
            if (rd_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL post_flush_read tags=%0d,%0d got=%b exp=00", 2*i, 2*i+1, rd_valid);
            end
        end
        rd_en = 2'b00;
    endtask

    task automatic test_async_reset();
        cdb_valid = 1'b1; cdb_rob = 3'd4; cdb_result = 32'h0000_0044;
        tick();
        cdb_valid = 1'b0;
        rd_en = 2'b01; rd_rob = {3'd0, 3'd4};
        tick();
        rd_en = 2'b00;
        vectors++;
        if (rd_valid[0] !== 1'b1 || rd_value[31:0] !== 32'h44) begin
            miscompares++;
            $display("FAIL pre_reset_read got=%b/%h exp=1/%h", rd_valid[0], rd_value[31:0], 32'h44);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (rd_valid !== 2'b00 || rd_value !== 64'h0) begin
            miscompares++;
            $display("FAIL async_reset_out got=%b/%h exp=00/0", rd_valid, rd_value);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_en = 2'b11; rd_rob = {3'(2*i+1), 3'(2*i)};
            tick();
            vectors++;
            if (rd_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL post_reset_read tags=%0d,%0d got=%b exp=00", 2*i, 2*i+1, rd_valid);
            end
        end
        rd_en = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_cdb_then_read();
        test_bypass();
        test_commit();
        test_multi_port();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
